// File: rtl/seg_scan_driver.sv
// ---------------------------------------------------------------------------
// seg_scan_driver
//
// Purpose:
//   Time-multiplexes four 5-bit digit codes onto a 4-digit common-anode
//   7-segment display. All four codes are latched together once per frame,
//   so a rotation step upstream can never tear the picture mid-frame. A
//   one-cycle frame pulse marks each capture and serves as the time base
//   for the rotation-state generator.
//
// Parameters:
//   REFRESH_DIV  - clock cycles per digit slot (2 .. 2**20)
//   BLANK_CYCLES - dead-time cycles at the end of each slot; only used when
//                  SCAN_BLANKING_EN is defined; must be < REFRESH_DIV
//
// Optional feature macro:
//   SCAN_BLANKING_EN - when defined, the anode is switched off for the last
//                      BLANK_CYCLES cycles of every slot to suppress ghosting.
//                      When undefined, the anode stays on for the whole slot.
//
// Ports:
//   clk        in   system clock
//   rst_n      in   synchronous active-low reset
//   seg0..seg3 in   5-bit codes, seg0 = rightmost digit (an[0]),
//                   seg3 = leftmost digit (an[3])
//   blank_all  in   forces all anodes off while high
//   an         out  anode enables, active-low, registered
//   seg        out  segments {g,f,e,d,c,b,a}, active-low, registered
//   frame_tick out  one-cycle pulse following each frame capture
// ---------------------------------------------------------------------------
module seg_scan_driver #(
  parameter int REFRESH_DIV  = 100000,
  parameter int BLANK_CYCLES = 1000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [4:0] seg0,
  input  logic [4:0] seg1,
  input  logic [4:0] seg2,
  input  logic [4:0] seg3,
  input  logic       blank_all,
  output logic [3:0] an,
  output logic [6:0] seg,
  output logic       frame_tick
);

  localparam int CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;

  // Reject illegal parameter combinations at elaboration time.
  if (REFRESH_DIV < 2 || REFRESH_DIV > (1 << 20)) begin : g_bad_div
    $error("seg_scan_driver: REFRESH_DIV out of range 2..2**20");
  end
  if (BLANK_CYCLES >= REFRESH_DIV) begin : g_bad_blank
    $error("seg_scan_driver: BLANK_CYCLES must be smaller than REFRESH_DIV");
  end

`ifdef SCAN_BLANKING_EN
  localparam logic [CW-1:0] BLANK_START = CW'(REFRESH_DIV - BLANK_CYCLES);
`endif

  logic [CW-1:0]  slot_cnt_q, slot_cnt_d;
  logic [1:0]     idx_q, idx_d;
  logic [3:0][4:0] shadow_q, shadow_d;
  logic [3:0]     an_q, an_d;
  logic [6:0]     seg_q, seg_d;
  logic           frame_tick_q, frame_tick_d;
  logic           slot_wrap;
  logic           capture;

  // Code to active-low segment pattern {g,f,e,d,c,b,a}.
  function automatic logic [6:0] decode(input logic [4:0] code);
    logic [6:0] pat;
    case (code)
      5'd0:    pat = 7'b1000000;
      5'd1:    pat = 7'b1111001;
      5'd2:    pat = 7'b0100100;
      5'd3:    pat = 7'b0110000;
      5'd4:    pat = 7'b0011001;
      5'd5:    pat = 7'b0010010;
      5'd6:    pat = 7'b0000010;
      5'd7:    pat = 7'b1111000;
      5'd8:    pat = 7'b0000000;
      5'd9:    pat = 7'b0010000;
      5'd10:   pat = 7'b0001000;
      5'd11:   pat = 7'b0000011;
      5'd12:   pat = 7'b1000110;
      5'd13:   pat = 7'b0100001;
      5'd14:   pat = 7'b0000110;
      5'd15:   pat = 7'b0001110;
      5'd17:   pat = 7'b0111111;
      5'd18:   pat = 7'b0001001;
      5'd19:   pat = 7'b1000111;
      5'd20:   pat = 7'b0001100;
      5'd21:   pat = 7'b1000001;
      5'd22:   pat = 7'b0101111;
      5'd23:   pat = 7'b0101011;
      5'd24:   pat = 7'b0100011;
      default: pat = 7'b1111111;
    endcase
    return pat;
  endfunction

  // Next-state logic. The outputs are computed from the post-edge counter,
  // index and shadow values so the digit shown always matches the slot and
  // the code latched for that slot, including on the capture edge itself.
  always_comb begin
    slot_wrap    = (slot_cnt_q == CW'(REFRESH_DIV - 1));
    capture      = (slot_cnt_q == '0) && (idx_q == 2'd0);
    slot_cnt_d   = slot_wrap ? '0 : slot_cnt_q + 1'b1;
    idx_d        = slot_wrap ? idx_q + 2'd1 : idx_q;
    shadow_d     = capture ? {seg3, seg2, seg1, seg0} : shadow_q;
    seg_d        = decode(shadow_d[idx_d]);
    an_d         = ~(4'b0001 << idx_d);
`ifdef SCAN_BLANKING_EN
    // Dead-time at the tail of each slot before the anode moves on.
    if (slot_cnt_d >= BLANK_START) begin
      an_d = 4'b1111;
    end
`endif
    if (blank_all) begin
      an_d = 4'b1111;
    end
    frame_tick_d = capture;
  end

  // State and output registers. Reset parks the scan at slot 0 of digit 0
  // with blank shadow codes, so the first edge after release captures.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      slot_cnt_q   <= '0;
      idx_q        <= 2'd0;
      shadow_q     <= {4{5'd16}};
      an_q         <= 4'b1111;
      seg_q        <= 7'b1111111;
      frame_tick_q <= 1'b0;
    end else begin
      slot_cnt_q   <= slot_cnt_d;
      idx_q        <= idx_d;
      shadow_q     <= shadow_d;
      an_q         <= an_d;
      seg_q        <= seg_d;
      frame_tick_q <= frame_tick_d;
    end
  end

  assign an         = an_q;
  assign seg        = seg_q;
  assign frame_tick = frame_tick_q;

endmodule

// File: tb/tb_seg_scan_driver.sv
// ---------------------------------------------------------------------------
// tb_seg_scan_driver
//
// Purpose:
//   Self-checking bench for seg_scan_driver with REFRESH_DIV=4 and
//   BLANK_CYCLES=1. A timeline model derives the expected outputs from the
//   number of clock edges since reset release, and is compared against the
//   DUT on every cycle. Directed checkpoints with hand-computed literals are
//   placed along the same run. Honours SCAN_BLANKING_EN like the DUT.
// ---------------------------------------------------------------------------
module tb_seg_scan_driver;

  localparam int DIV   = 4;
  localparam int BLANK = 1;

`ifdef SCAN_BLANKING_EN
  localparam logic [3:0] AN_TAIL0 = 4'b1111;
  localparam logic [3:0] AN_TAIL1 = 4'b1111;
`else
  localparam logic [3:0] AN_TAIL0 = 4'b1110;
  localparam logic [3:0] AN_TAIL1 = 4'b1101;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic [4:0] seg0, seg1, seg2, seg3;
  logic       blank_all;
  logic [3:0] an;
  logic [6:0] seg;
  logic       frame_tick;

  int checks = 0;
  int errors = 0;

  seg_scan_driver #(
    .REFRESH_DIV (DIV),
    .BLANK_CYCLES(BLANK)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .seg0      (seg0),
    .seg1      (seg1),
    .seg2      (seg2),
    .seg3      (seg3),
    .blank_all (blank_all),
    .an        (an),
    .seg       (seg),
    .frame_tick(frame_tick)
  );

  always #5 clk = ~clk;

  // Segment patterns straight from the display code table.
  function automatic logic [6:0] patternOf(input logic [4:0] code);
    logic [6:0] p;
    case (code)
      5'd0:  p = 7'b1000000;  5'd1:  p = 7'b1111001;
      5'd2:  p = 7'b0100100;  5'd3:  p = 7'b0110000;
      5'd4:  p = 7'b0011001;  5'd5:  p = 7'b0010010;
      5'd6:  p = 7'b0000010;  5'd7:  p = 7'b1111000;
      5'd8:  p = 7'b0000000;  5'd9:  p = 7'b0010000;
      5'd10: p = 7'b0001000;  5'd11: p = 7'b0000011;
      5'd12: p = 7'b1000110;  5'd13: p = 7'b0100001;
      5'd14: p = 7'b0000110;  5'd15: p = 7'b0001110;
      5'd17: p = 7'b0111111;  5'd18: p = 7'b0001001;
      5'd19: p = 7'b1000111;  5'd20: p = 7'b0001100;
      5'd21: p = 7'b1000001;  5'd22: p = 7'b0101111;
      5'd23: p = 7'b0101011;  5'd24: p = 7'b0100011;
      default: p = 7'b1111111;
    endcase
    return p;
  endfunction

  // Timeline model: kModel counts edges since reset release. Edge k puts
  // the display in slot position k mod DIV of digit (k div DIV) mod 4, and
  // edges with k mod 4*DIV == 1 are frame captures.
  int         kModel = 0;
  logic       modelValid = 1'b0;
  logic [4:0] shadowModel [4];
  logic [3:0] expAn;
  logic [6:0] expSeg;
  logic       expTick;

  always @(posedge clk) begin
    int slotPos;
    int digit;
    if (rst_n !== 1'b1) begin
      kModel     = 0;
      for (int i = 0; i < 4; i++) shadowModel[i] = 5'd16;
      expAn      = 4'b1111;
      expSeg     = 7'b1111111;
      expTick    = 1'b0;
      modelValid = 1'b1;
    end else begin
      kModel  = kModel + 1;
      slotPos = kModel % DIV;
      digit   = (kModel / DIV) % 4;
      expTick = ((kModel % (4 * DIV)) == 1);
      if (expTick) begin
        shadowModel[0] = seg0;
        shadowModel[1] = seg1;
        shadowModel[2] = seg2;
        shadowModel[3] = seg3;
      end
      expSeg = patternOf(shadowModel[digit]);
      expAn  = 4'b1111;
      if (!blank_all) expAn[digit] = 1'b0;
`ifdef SCAN_BLANKING_EN
      if (slotPos >= DIV - BLANK) expAn = 4'b1111;
`endif
    end
  end

  // Per-cycle comparison of the DUT against the model, 1 time unit after
  // each edge.
  always @(posedge clk) begin
    #1;
    if (modelValid) begin
      checks++;
      if (an !== expAn) begin
        errors++;
        $display("[TB] FAIL model_an k=%0d got %b exp %b", kModel, an, expAn);
      end
      checks++;
      if (seg !== expSeg) begin
        errors++;
        $display("[TB] FAIL model_seg k=%0d got %b exp %b", kModel, seg, expSeg);
      end
      checks++;
      if (frame_tick !== expTick) begin
        errors++;
        $display("[TB] FAIL model_tick k=%0d got %b exp %b", kModel, frame_tick, expTick);
      end
    end
  end

  // Hand-computed checkpoint against literal values.
  task automatic checkOutput(input string name, input logic [3:0] wantAn,
                             input logic [6:0] wantSeg, input logic wantTick);
    checks++;
    if (an !== wantAn || seg !== wantSeg || frame_tick !== wantTick) begin
      errors++;
      $display("[TB] FAIL %s got an=%b seg=%b tick=%b exp an=%b seg=%b tick=%b",
               name, an, seg, frame_tick, wantAn, wantSeg, wantTick);
    end
  endtask

  // Drive new inputs on the falling edge so they are taken at the next edge.
  task automatic applyStimulus(input logic [4:0] c0, input logic [4:0] c1,
                               input logic [4:0] c2, input logic [4:0] c3,
                               input logic blk, input logic rstn);
    @(negedge clk);
    seg0      = c0;
    seg1      = c1;
    seg2      = c2;
    seg3      = c3;
    blank_all = blk;
    rst_n     = rstn;
  endtask

  // Advance to just after edge number target since reset release.
  task automatic stepTo(input int target);
    int guard = 0;
    do begin
      @(posedge clk);
      #2;
      guard++;
    end while (kModel < target && guard < 2000);
    if (kModel != target) begin
      checks++;
      errors++;
      $display("[TB] FAIL step_timeout got k=%0d exp k=%0d", kModel, target);
    end
  endtask

  initial begin
    #50000;
    $display("[TB] FAIL watchdog got timeout exp finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst_n     = 1'b0;
    blank_all = 1'b0;
    seg0 = 5'd1; seg1 = 5'd2; seg2 = 5'd3; seg3 = 5'd4;
    repeat (3) @(posedge clk);
    #2;
    checkOutput("reset_state", 4'b1111, 7'b1111111, 1'b0);
    applyStimulus(5'd1, 5'd2, 5'd3, 5'd4, 1'b0, 1'b1);

    $display("[TB] first frame with codes 1,2,3,4");
    stepTo(1);  checkOutput("capture_k1",  4'b1110,  7'b1111001, 1'b1);
    stepTo(3);  checkOutput("slot_tail_k3", AN_TAIL0, 7'b1111001, 1'b0);
    stepTo(5);  checkOutput("digit1_k5",   4'b1101,  7'b0100100, 1'b0);
    stepTo(6);
    applyStimulus(5'd8, 5'd2, 5'd3, 5'd4, 1'b0, 1'b1);
    stepTo(7);  checkOutput("slot_tail_k7", AN_TAIL1, 7'b0100100, 1'b0);
    stepTo(9);  checkOutput("digit2_k9",   4'b1011,  7'b0110000, 1'b0);
    stepTo(13); checkOutput("digit3_k13",  4'b0111,  7'b0011001, 1'b0);
    stepTo(16); checkOutput("old_code_k16", 4'b1110, 7'b1111001, 1'b0);
    stepTo(17); checkOutput("new_code_k17", 4'b1110, 7'b0000000, 1'b1);

    $display("[TB] special codes 16,17,18,31");
    applyStimulus(5'd16, 5'd17, 5'd18, 5'd31, 1'b0, 1'b1);
    stepTo(33); checkOutput("code16_k33",  4'b1110,  7'b1111111, 1'b1);
    stepTo(37); checkOutput("code17_k37",  4'b1101,  7'b0111111, 1'b0);
    stepTo(41); checkOutput("code18_k41",  4'b1011,  7'b0001001, 1'b0);
    stepTo(45); checkOutput("code31_k45",  4'b0111,  7'b1111111, 1'b0);

    $display("[TB] blank_all for 10 cycles");
    stepTo(54);
    applyStimulus(5'd16, 5'd17, 5'd18, 5'd31, 1'b1, 1'b1);
    stepTo(55); checkOutput("blank_on_k55", 4'b1111, 7'b0111111, 1'b0);
    stepTo(64);
    applyStimulus(5'd16, 5'd17, 5'd18, 5'd31, 1'b0, 1'b1);
    stepTo(65); checkOutput("blank_off_k65", 4'b1110, 7'b1111111, 1'b1);

    $display("[TB] reset during digit 2");
    applyStimulus(5'd5, 5'd6, 5'd7, 5'd9, 1'b0, 1'b1);
    stepTo(73);
    applyStimulus(5'd5, 5'd6, 5'd7, 5'd9, 1'b0, 1'b0);
    @(posedge clk);
    #2;
    checkOutput("mid_reset", 4'b1111, 7'b1111111, 1'b0);
    applyStimulus(5'd5, 5'd6, 5'd7, 5'd9, 1'b0, 1'b1);
    stepTo(1);  checkOutput("restart_k1",  4'b1110,  7'b0010010, 1'b1);
    stepTo(5);  checkOutput("restart_k5",  4'b1101,  7'b0000010, 1'b0);
    stepTo(13); checkOutput("restart_k13", 4'b0111,  7'b0010000, 1'b0);
    stepTo(17); checkOutput("restart_k17", 4'b1110,  7'b0010010, 1'b1);
    stepTo(40);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/seg_scan_driver.md
Name: seg_scan_driver

Overview:
- Consumes the four 5-bit digit codes (seg0..seg3) produced by the digit-rotation stage.
- Drives a 4-digit common-anode 7-segment display by time-multiplexing anodes and decoding codes to segment patterns.
- Latches all four codes once per frame so a rotation step never tears mid-frame.
- Emits a frame pulse that the rotation-state generator uses as its time base.

Parameters:
- REFRESH_DIV, 100000, clock cycles per digit slot; legal range 2..2^20.
- BLANK_CYCLES, 1000, dead-time cycles at the end of each slot; only used with SCAN_BLANKING_EN; must be < REFRESH_DIV.

Ports:
- clk  input  1  system clock
- rst_n  input  1  synchronous active-low reset
- seg0  input  5  code for rightmost digit (an[0])
- seg1  input  5  code for digit an[1]
- seg2  input  5  code for digit an[2]
- seg3  input  5  code for leftmost digit (an[3])
- blank_all  input  1  forces all anodes off while high
- an  output  4  anode enables, active-low, registered
- seg  output  7  segments {g,f,e,d,c,b,a}, active-low, registered
- frame_tick  output  1  one-cycle pulse on each frame capture

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - slot_cnt=0, idx=0, shadow codes = 16 (blank).
  - an=4'b1111, seg=7'b1111111, frame_tick=0.
  - Reset mid-frame aborts the frame; the scan restarts at idx 0.
- slot_cnt:
  - Counts 0..REFRESH_DIV-1 and wraps.
  - On wrap, idx increments 0->1->2->3->0.
- Capture:
  - Occurs on the edge where current slot_cnt==0 and idx==0; this is the first edge after reset release, then once every 4*REFRESH_DIV cycles.
  - Shadow registers load seg0..seg3.
  - frame_tick=1 for exactly the following cycle; 0 otherwise.
  - Input changes at any other time have no effect until the next capture.
- Output registers load on the same edge as slot_cnt/idx/shadow, using the post-edge values, so display and shadow are never misaligned:
  - an = one-hot-low of idx; idx 0 -> 4'b1110, idx 3 -> 4'b0111.
  - seg = decode(shadow[idx]).
- blank_all=1: an loads 4'b1111. Counters, capture and frame_tick continue unaffected.
- Decode table (active-low, bits g..a):
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000
  - 8=0000000, 9=0010000, A=0001000, b=0000011, C=1000110, d=0100001, E=0000110, F=0001110
  - 16 blank=1111111, 17 '-'=0111111, 18 H=0001001, 19 L=1000111, 20 P=0001100, 21 U=1000001, 22 r=0101111, 23 n=0101011, 24 o=0100011
  - 25..31 blank.
- Frame period: 4*REFRESH_DIV cycles exactly, independent of blank_all and input activity.

Optional Feature:
- Macro: SCAN_BLANKING_EN
- Defined:
  - an loads 4'b1111 whenever post-edge slot_cnt >= REFRESH_DIV-BLANK_CYCLES, giving BLANK_CYCLES of dead-time before each anode change to suppress ghosting.
  - seg still updates per the normal rules.
- Undefined: no dead-time; the anode is active for all REFRESH_DIV cycles of the slot; BLANK_CYCLES is ignored.

Test Plan:
- REFRESH_DIV=4; reset 3 cycles, release with seg0..3=1,2,3,4:
  - Cycle 1 after release: an=1110, seg=1111001, frame_tick=1.
  - an then steps 1101/1011/0111 every 4 cycles with seg=2/3/4 patterns.
  - frame_tick recurs every 16 cycles.
- Change seg0 from 1 to 8 at frame cycle 6: no seg change until the next capture; seg=0000000 on the next digit-0 slot.
- Codes 16, 17, 18, 31 on seg0..3: observed patterns 1111111, 0111111, 0001001, 1111111.
- blank_all=1 for 10 cycles mid-frame: an=1111 the cycle after assertion, resumes correct idx the cycle after deassertion; frame_tick spacing stays 16.
- rst_n=0 for one edge during idx 2: next cycle an=1111, seg=1111111; after release, restart at idx 0 with a fresh capture and frame_tick.
- With SCAN_BLANKING_EN, REFRESH_DIV=4, BLANK_CYCLES=1: each slot shows 3 cycles of active anode then 1 cycle of an=1111; without the macro, the anode is active all 4 cycles.
